myo_spi_scheduler: RTL and testbench
====================================

# myo_spi_scheduler

Periodic SPI poll scheduler for motor boards. It raises a fixed-rate sweep tick and walks an enable mask of motor boards in index order. For each enabled board it runs one req/done transaction with the shared SPI master, driving that board's slave select. It sits between the Avalon-configured control registers and the SPI master, and reports sweep completion, overrun and per-board timeout errors to the PID/HPS side.

## Interface
Parameters:
- NUM_MOTORS, 6, number of motor boards / slave selects (1..32)
- PERIOD_CYCLES, 50000, sweep period in clk cycles (1 kHz at 50 MHz), ≥ 2
- GAP_CYCLES, 4, idle cycles with all selects high between transactions (0 allowed)
- TIMEOUT_CYCLES, 4096, max cycles in a transaction before abort (≥ 2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- enable  in  1  scheduling enabled
- motor_mask  in  NUM_MOTORS  boards to poll; bit i = board i
- err_clr  in  1  clears err_flags and overrun
- spi_req  out  1  transaction request, held until done/abort
- spi_sel  out  $clog2(NUM_MOTORS) (min 1)  index of active board
- ss_n  out  NUM_MOTORS  one-cold slave select, low only during spi_req
- spi_done  in  1  one-cycle pulse from SPI master, transaction finished
- spi_abort  out  1  one-cycle pulse, transaction abandoned on timeout
- cycle_done  out  1  one-cycle pulse, sweep finished
- sweep_count  out  16  completed sweeps, wraps 0xFFFF→0
- overrun  out  1  sticky: tick arrived while sweep active
- err_flags  out  NUM_MOTORS  sticky per-board timeout flags

## Operation
- Reset values: spi_req=0, spi_sel=0, ss_n=all 1, spi_abort=0, cycle_done=0, sweep_count=0, overrun=0, err_flags=0. The period counter and idx are 0. State is IDLE.
- Period counter: counts 0..PERIOD_CYCLES-1 while enable=1, and tick=1 when it equals PERIOD_CYCLES-1. While enable=0 it is held at 0.
- States: IDLE, SCAN, REQ, GAP, DONE.
- IDLE: on tick, latch motor_mask→mask_q, set idx=0, go to SCAN. Later mask changes do not affect the current sweep.
- SCAN: tests one index per cycle.
  - mask_q[idx]=1 → REQ.
  - Otherwise, if idx=NUM_MOTORS-1 → DONE; else idx+1 and stay in SCAN.
- REQ: spi_req=1, spi_sel=idx, ss_n[idx]=0.
  - On spi_done → leave REQ.
  - On timeout (TIMEOUT_CYCLES in REQ with no done) → pulse spi_abort, set err_flags[idx], leave REQ.
  - Leaving REQ: if idx=NUM_MOTORS-1 → DONE. Otherwise idx+1, then GAP if GAP_CYCLES>0, else SCAN.
- GAP: spi_req=0, ss_n all high for GAP_CYCLES cycles → SCAN.
- DONE: cycle_done=1 for one cycle, sweep_count+1 → IDLE.
- Boundary rules:
  - A tick outside IDLE sets overrun; that tick is dropped, not queued.
  - spi_done outside REQ is ignored.
  - spi_done and timeout in the same cycle: done wins, no error.
  - err_clr in the same cycle as a new error or overrun: set wins.
  - enable falling mid-sweep: the current transaction and sweep run to DONE, and no new tick follows.
  - An all-zero mask still sweeps: NUM_MOTORS SCAN cycles, then cycle_done.
  - Reset mid-transaction drops spi_req and ss_n immediately (asynchronous).

## Timing
- All outputs are registered.
- Tick at cycle T → SCAN at T+1. If mask_q[0]=1: spi_req=1 and ss_n[0]=0 at T+2.
- spi_done at cycle D → spi_req=0 and ss_n all 1 at D+1.
- Next board's ss_n low at D+1+GAP_CYCLES+k+1, where k is the number of masked-off indices skipped.
- Timeout: spi_abort and err_flags set at the cycle after TIMEOUT_CYCLES REQ cycles; spi_req drops in that same cycle.
- cycle_done asserts one cycle after the last board's done, or one cycle after the last SCAN.

## Configuration
- SCHEDULER_TIMEOUT_EN defined: timeout watchdog, spi_abort and err_flags behave as above.
- SCHEDULER_TIMEOUT_EN undefined:
  - REQ waits indefinitely for spi_done.
  - spi_abort and err_flags are constant 0; err_clr clears overrun only.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Config: NUM_MOTORS=6, PERIOD_CYCLES=100, GAP_CYCLES=2; mask=0b000101; SPI model returns done 10 cycles after req.
  - ss_n=111110 then 111011, spi_sel=0 then 2, one cycle_done per sweep, sweep_count=1 after the first sweep.
- mask=0, enable=1 for 350 cycles → 3 cycle_done pulses 100 cycles apart, spi_req never high.
- Model delays done 150 cycles per board with mask=0x3F → overrun=1. Then err_clr pulse → overrun=0; after the model is restored it stays 0.
- SCHEDULER_TIMEOUT_EN, TIMEOUT_CYCLES=20, board 3 never answers:
  - spi_abort pulses 20 cycles after req, err_flags=0b001000.
  - Board 4 is still polled.
  - done and timeout in the same cycle → no flag.
- Async reset asserted while ss_n[1]=0 → ss_n=all 1 and spi_req=0 without a clk edge. After release, no req before the next tick.
- Mask changed mid-sweep from 0x3F to 0x01 → current sweep still polls all 6. The next sweep polls board 0 only.

Source files
------------

// File: rtl/myo_spi_scheduler.sv
// Periodic SPI poll scheduler: raises a fixed-rate sweep tick and runs one req/done
// transaction per enabled motor board. Define SCHEDULER_TIMEOUT_EN for the timeout watchdog.
module myo_spi_scheduler #(
    parameter int NUM_MOTORS     = 6,
    parameter int PERIOD_CYCLES  = 50000,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int SEL_W = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [NUM_MOTORS-1:0] motor_mask,
    input  logic                  err_clr,
    output logic                  spi_req,
    output logic [SEL_W-1:0]      spi_sel,
    output logic [NUM_MOTORS-1:0] ss_n,
    input  logic                  spi_done,
    output logic                  spi_abort,
    output logic                  cycle_done,
    output logic [15:0]           sweep_count,
    output logic                  overrun,
    output logic [NUM_MOTORS-1:0] err_flags
);

    localparam int CNT_W = $clog2(PERIOD_CYCLES);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [SEL_W-1:0] IDX_LAST    = SEL_W'(NUM_MOTORS - 1);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_REQ, S_GAP, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      period_q, period_d;
    logic [NUM_MOTORS-1:0] mask_q, mask_d;
    logic [SEL_W-1:0]      idx_q, idx_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  spi_req_q, spi_req_d;
    logic [SEL_W-1:0]      spi_sel_q, spi_sel_d;
    logic [NUM_MOTORS-1:0] ss_n_q, ss_n_d;
    logic                  cycle_done_q, cycle_done_d;
    logic [15:0]           sweep_count_q, sweep_count_d;
    logic                  overrun_q, overrun_d;
    logic                  tick;
    logic                  timeout;

`ifdef SCHEDULER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0]       to_q, to_d;
    logic                  spi_abort_q, spi_abort_d;
    logic [NUM_MOTORS-1:0] err_flags_q, err_flags_d;
`else
    logic [31:0] timeout_cycles_unused;
    assign timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

    // Free-running period counter; held at zero while scheduling is disabled.
    always_comb begin
        tick = enable && (period_q == PERIOD_LAST);
        if (!enable || tick) period_d = '0;
        else                 period_d = period_q + 1'b1;
    end

    always_comb begin
        // NOTE: every next-state value gets a hold default first, so no branch leaves a latch.
        state_d       = state_q;
        mask_d        = mask_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        sweep_count_d = sweep_count_q;
        timeout       = 1'b0;
`ifdef SCHEDULER_TIMEOUT_EN
        to_d          = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    mask_d  = motor_mask;
                    idx_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (mask_q[idx_q])          state_d = S_REQ;
                else if (idx_q == IDX_LAST) state_d = S_DONE;
                else                        idx_d   = idx_q + 1'b1;
            end
            S_REQ: begin
`ifdef SCHEDULER_TIMEOUT_EN
                to_d    = to_q + 1'b1;
                timeout = !spi_done && (to_q == TO_LAST);
`endif
                if (spi_done || timeout) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        gap_d   = '0;
                        state_d = (GAP_CYCLES > 0) ? S_GAP : S_SCAN;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_SCAN;
                else                   gap_d   = gap_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of what the next state implies.
        spi_req_d = (state_d == S_REQ);
        spi_sel_d = spi_req_d ? idx_d : spi_sel_q;
        ss_n_d    = '1;
        if (spi_req_d) ss_n_d[idx_d] = 1'b0;

        cycle_done_d = (state_d == S_DONE);
        if (cycle_done_d) sweep_count_d = sweep_count_q + 16'd1;

        // A dropped tick outranks a simultaneous clear.
        overrun_d = (err_clr ? 1'b0 : overrun_q) | (tick && (state_q != S_IDLE));

`ifdef SCHEDULER_TIMEOUT_EN
        spi_abort_d = timeout;
        err_flags_d = err_clr ? '0 : err_flags_q;
        if (timeout) err_flags_d[idx_q] = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            period_q      <= '0;
            mask_q        <= '0;
            idx_q         <= '0;
            gap_q         <= '0;
            spi_req_q     <= 1'b0;
            spi_sel_q     <= '0;
            ss_n_q        <= '1;
            cycle_done_q  <= 1'b0;
            sweep_count_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            period_q      <= period_d;
            mask_q        <= mask_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            spi_req_q     <= spi_req_d;
            spi_sel_q     <= spi_sel_d;
            ss_n_q        <= ss_n_d;
            cycle_done_q  <= cycle_done_d;
            sweep_count_q <= sweep_count_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef SCHEDULER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_q        <= '0;
            spi_abort_q <= 1'b0;
            err_flags_q <= '0;
        end else begin
            to_q        <= to_d;
            spi_abort_q <= spi_abort_d;
            err_flags_q <= err_flags_d;
        end
    end

    assign spi_abort = spi_abort_q;
    assign err_flags = err_flags_q;
`else
    assign spi_abort = 1'b0;
    assign err_flags = '0;
`endif

    assign spi_req     = spi_req_q;
    assign spi_sel     = spi_sel_q;
    assign ss_n        = ss_n_q;
    assign cycle_done  = cycle_done_q;
    assign sweep_count = sweep_count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_myo_spi_scheduler.sv
// Scoreboard bench for myo_spi_scheduler: stimulus pushes expected events with their cycle,
// a negedge monitor pops and compares whenever the DUT starts a request, aborts or ends a sweep.
module tb_myo_spi_scheduler;

    localparam int NM     = 6;
    localparam int PERIOD = 100;
    localparam int GAP    = 2;
    localparam int TO     = 20;
`ifdef SCHEDULER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum int {EV_REQ, EV_DONE, EV_ABORT} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        int          cyc;
        logic [31:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [NM-1:0] motor_mask;
    logic          err_clr;
    logic          spi_req;
    logic [2:0]    spi_sel;
    logic [NM-1:0] ss_n;
    logic          spi_done;
    logic          spi_abort;
    logic          cycle_done;
    logic [15:0]   sweep_count;
    logic          overrun;
    logic [NM-1:0] err_flags;

    int            cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;
    int            model_delay = 10;
    int            silent_board = -1;
    int            exp_sweep = 0;
    logic [NM-1:0] exp_err = '0;
    ev_t           exp_q[$];

    myo_spi_scheduler #(
        .NUM_MOTORS    (NM),
        .PERIOD_CYCLES (PERIOD),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .motor_mask (motor_mask),
        .err_clr    (err_clr),
        .spi_req    (spi_req),
        .spi_sel    (spi_sel),
        .ss_n       (ss_n),
        .spi_done   (spi_done),
        .spi_abort  (spi_abort),
        .cycle_done (cycle_done),
        .sweep_count(sweep_count),
        .overrun    (overrun),
        .err_flags  (err_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic [31:0] req_data(input int sel, input logic [NM-1:0] ssn);
        return {23'd0, 3'(sel), ssn};
    endfunction

    task automatic push_ev(input ev_kind_e kind, input int c, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Expected events of one sweep whose tick falls in cycle t, derived from the timing rules:
    // SCAN at t+1, req one cycle after its SCAN, req drops the cycle after done (or aborts
    // TO cycles after req), GAP cycles of gap, then SCAN of the next index.
    task automatic push_sweep(input int t, input logic [NM-1:0] m, input int delay, input int silent);
        int c = t + 1;
        int e = 0;
        for (int i = 0; i < NM; i++) begin
            if (m[i]) begin
                int r = c + 1;
                push_ev(EV_REQ, r, req_data(i, ~(NM'(1) << i)));
                if (TO_EN && (i == silent || delay >= TO)) begin
                    e = r + TO;
                    exp_err[i] = 1'b1;
                    push_ev(EV_ABORT, e, {26'd0, exp_err});
                end else begin
                    e = r + delay + 1;
                end
                c = e + GAP;
            end else begin
                e = c + 1;
                c = c + 1;
            end
        end
        exp_sweep++;
        push_ev(EV_DONE, e, {16'd0, 16'(exp_sweep)});
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic run_sweep(input logic [NM-1:0] m, input int delay, input int silent);
        int t;
        model_delay  = delay;
        silent_board = silent;
        @(negedge clk);
        motor_mask = m;
        enable     = 1'b1;
        t = cyc + PERIOD - 1;
        push_sweep(t, m, delay, silent);
        wait_drain(300);
        enable = 1'b0;
    endtask

    task automatic observe(input ev_kind_e kind, input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: kind %0d data 0x%0h at cycle %0d, expected none", kind, data, cyc);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", 64'(kind), 64'(e.kind));
            check("ev_cycle", 64'(cyc), 64'(e.cyc));
            check("ev_data", 64'(data), 64'(e.data));
        end
    endtask

    // SPI master model: done pulse `model_delay` cycles after req rises; silent board never answers.
    initial begin
        int age = 0;
        spi_done = 1'b0;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (spi_req === 1'b1) begin
                age++;
                if (age == model_delay + 1 && int'(spi_sel) != silent_board) spi_done = 1'b1;
            end else begin
                age = 0;
            end
        end
    end

    // Monitor: event order within one cycle is abort, sweep end, new request.
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_abort === 1'b1) observe(EV_ABORT, {26'd0, err_flags});
            if (cycle_done === 1'b1) observe(EV_DONE, {16'd0, sweep_count});
            if (spi_req === 1'b1 && !prev_req) observe(EV_REQ, req_data(int'(spi_sel), ss_n));
            if (spi_req !== 1'b1 && prev_req) check("ss_n_release", 64'(ss_n), 64'(6'h3F));
            prev_req = (spi_req === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t;
        int n;
        // NOTE: inputs are driven with blocking assignments on the negedge, away from the sampling edge.
        reset_n    = 1'b0;
        enable     = 1'b0;
        motor_mask = '0;
        err_clr    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_spi_req", 64'(spi_req), 64'(0));
        check("rst_spi_sel", 64'(spi_sel), 64'(0));
        check("rst_ss_n", 64'(ss_n), 64'(6'h3F));
        check("rst_spi_abort", 64'(spi_abort), 64'(0));
        check("rst_cycle_done", 64'(cycle_done), 64'(0));
        check("rst_sweep_count", 64'(sweep_count), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        check("rst_err_flags", 64'(err_flags), 64'(0));
        reset_n = 1'b1;

        // Mask 0b000101, two sweeps: boards 0 and 2, hand-computed cycles from the tick.
        @(negedge clk);
        motor_mask = 6'b000101;
        enable     = 1'b1;
        t = cyc + PERIOD - 1;
        push_ev(EV_REQ, t + 2, req_data(0, 6'b111110));
        push_ev(EV_REQ, t + 17, req_data(2, 6'b111011));
        push_ev(EV_DONE, t + 33, 32'd1);
        push_ev(EV_REQ, t + 102, req_data(0, 6'b111110));
        push_ev(EV_REQ, t + 117, req_data(2, 6'b111011));
        push_ev(EV_DONE, t + 133, 32'd2);
        exp_sweep = 2;
        wait_drain(300);
        enable = 1'b0;
        check("sweep_count_two", 64'(sweep_count), 64'(2));

        // Empty mask: three sweeps of six SCAN cycles, one per period, no requests.
        @(negedge clk);
        motor_mask = '0;
        enable     = 1'b1;
        t = cyc + PERIOD - 1;
        for (int k = 0; k < 3; k++) push_sweep(t + k * PERIOD, 6'h00, 10, -1);
        wait_cycle(t + 251);
        enable = 1'b0;
        wait_drain(50);

        // Slow SPI master: tick at t+100 lands mid-sweep; enable drops mid-sweep afterwards.
        model_delay = 150;
        @(negedge clk);
        motor_mask = 6'h3F;
        enable     = 1'b1;
        t = cyc + PERIOD - 1;
        push_sweep(t, 6'h3F, 150, -1);
        wait_cycle(t + PERIOD + 1);
        check("overrun_set", 64'(overrun), 64'(1));
        enable = 1'b0;
        wait_drain(1200);
        check("overrun_sticky", 64'(overrun), 64'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = '0;
        check("overrun_cleared", 64'(overrun), 64'(0));
        check("err_flags_cleared", 64'(err_flags), 64'(0));
        run_sweep(6'h3F, 10, -1);
        check("overrun_stays_clear", 64'(overrun), 64'(0));

`ifdef SCHEDULER_TIMEOUT_EN
        // Board 3 silent: abort 20 cycles after its req, board 4 still polled.
        run_sweep(6'b011000, 10, 3);
        check("err_flags_board3", 64'(err_flags), 64'(6'b001000));
        // Done on the last watchdog cycle wins over the timeout.
        run_sweep(6'b000001, TO - 1, -1);
        check("err_flags_done_wins", 64'(err_flags), 64'(6'b001000));
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = '0;
        check("err_flags_clr", 64'(err_flags), 64'(0));
`endif

        // Mask change mid-sweep only affects the following sweep.
        model_delay  = 10;
        silent_board = -1;
        @(negedge clk);
        motor_mask = 6'h3F;
        enable     = 1'b1;
        t = cyc + PERIOD - 1;
        push_sweep(t, 6'h3F, 10, -1);
        push_sweep(t + PERIOD, 6'h01, 10, -1);
        wait_cycle(t + 5);
        motor_mask = 6'h01;
        wait_drain(400);
        enable = 1'b0;

        // Asynchronous reset while board 1 is selected.
        @(negedge clk);
        motor_mask = 6'h3F;
        enable     = 1'b1;
        t = cyc + PERIOD - 1;
        push_sweep(t, 6'h3F, 10, -1);
        n = 0;
        while (ss_n[1] !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_now("wait_ss_n1_low");
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_ss_n", 64'(ss_n), 64'(6'h3F));
        check("async_rst_spi_req", 64'(spi_req), 64'(0));
        exp_q.delete();
        exp_sweep = 0;
        exp_err   = '0;
        @(negedge clk);
        @(negedge clk);
        check("async_rst_sweep_count", 64'(sweep_count), 64'(0));
        reset_n = 1'b1;
        t = cyc + PERIOD - 1;
        push_sweep(t, 6'h3F, 10, -1);
        wait_drain(400);
        enable = 1'b0;

        repeat (150) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
